// File: rtl/fetch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_pkg
// Shared definitions for the instruction-fetch path of the 8-bit CPU:
//   - opcode constants of the instruction set
//   - fetch FSM state encoding
//   - opcode length/legality decode, also used by the control unit
// -----------------------------------------------------------------------------
package fetch_sequencer_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    // Instruction set
    localparam logic [7:0] NOP     = 8'h00;
    localparam logic [7:0] LDA_IMM = 8'h10;
    localparam logic [7:0] LDA_DIR = 8'h11;
    localparam logic [7:0] LDB_IMM = 8'h12;
    localparam logic [7:0] LDB_DIR = 8'h13;
    localparam logic [7:0] STA_DIR = 8'h14;
    localparam logic [7:0] STB_DIR = 8'h15;
    localparam logic [7:0] ADD_AB  = 8'h20;
    localparam logic [7:0] SUB_AB  = 8'h21;
    localparam logic [7:0] AND_AB  = 8'h22;
    localparam logic [7:0] OR_AB   = 8'h23;
    localparam logic [7:0] XOR_AB  = 8'h24;
    localparam logic [7:0] NOT_A   = 8'h25;
    localparam logic [7:0] INC_A   = 8'h26;
    localparam logic [7:0] DEC_A   = 8'h27;
    localparam logic [7:0] BRA     = 8'h30;
    localparam logic [7:0] BMI     = 8'h31;
    localparam logic [7:0] BPL     = 8'h32;
    localparam logic [7:0] BEQ     = 8'h33;
    localparam logic [7:0] BNE     = 8'h34;
    localparam logic [7:0] BVS     = 8'h35;
    localparam logic [7:0] BVC     = 8'h36;
    localparam logic [7:0] BCS     = 8'h37;
    localparam logic [7:0] BCC     = 8'h38;
    localparam logic [7:0] HLT     = 8'hFF;

    typedef enum logic [2:0] {
        ST_FETCH_OP  = 3'd0,
        ST_LATCH_OP  = 3'd1,
        ST_FETCH_ARG = 3'd2,
        ST_LATCH_ARG = 3'd3,
        ST_VALID     = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    typedef struct packed {
        logic has_operand;
        logic legal;
    } op_info_t;

    // Operand length and legality of an opcode; unknown opcodes are 0-operand.
    function automatic op_info_t decode_op(input logic [7:0] op);
        op_info_t info;
        case (op)
            LDA_IMM, LDA_DIR, LDB_IMM, LDB_DIR, STA_DIR, STB_DIR,
            BRA, BMI, BPL, BEQ, BNE, BVS, BVC, BCS, BCC:
                info = '{has_operand: 1'b1, legal: 1'b1};
            NOP, ADD_AB, SUB_AB, AND_AB, OR_AB, XOR_AB, NOT_A, INC_A, DEC_A, HLT:
                info = '{has_operand: 1'b0, legal: 1'b1};
            default:
                info = '{has_operand: 1'b0, legal: 1'b0};
        endcase
        return info;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_if
// Bus between the fetch sequencer, the program ROM and the execute unit.
//   master : fetch sequencer side (drives ROM address and instruction bundle)
//   slave  : ROM / execute-unit side
// Optional macro ILLEGAL_TRAP_EN adds the illegal_op flag.
// -----------------------------------------------------------------------------
interface fetch_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] opcode;
    logic [DATA_W-1:0] operand;
    logic              has_operand;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;
    logic [ADDR_W-1:0] pc;
    logic              fetch_fault;
`ifdef ILLEGAL_TRAP_EN
    logic              illegal_op;
`endif

    modport master (
        input  rom_data, instr_ready, redirect_valid, redirect_addr,
        output rom_addr, opcode, operand, has_operand, instr_pc,
               instr_valid, pc, fetch_fault
`ifdef ILLEGAL_TRAP_EN
             , illegal_op
`endif
    );

    modport slave (
        output rom_data, instr_ready, redirect_valid, redirect_addr,
        input  rom_addr, opcode, operand, has_operand, instr_pc,
               instr_valid, pc, fetch_fault
`ifdef ILLEGAL_TRAP_EN
             , illegal_op
`endif
    );

endinterface

// File: rtl/fetch_sequencer_opcode_len_decode.sv
// -----------------------------------------------------------------------------
// opcode_len_decode
// Combinational opcode decoder.
//   opcode      in  8  raw opcode byte
//   has_operand out 1  instruction carries one operand byte
//   legal       out 1  opcode belongs to the instruction set
// -----------------------------------------------------------------------------
module opcode_len_decode
    import fetch_sequencer_pkg::*;
(
    input  logic [7:0] opcode,
    output logic       has_operand,
    output logic       legal
);
    op_info_t info_s;

    assign info_s      = decode_op(opcode);
    assign has_operand = info_s.has_operand;
    assign legal       = info_s.legal;

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Instruction-fetch controller: owns the PC, reads the 1-cycle-latency program
// ROM, assembles opcode + optional operand and presents the bundle over a
// valid/ready handshake. Handles redirects and out-of-window fetch faults.
// Ports:
//   clk    in  system clock, rising edge
//   reset  in  asynchronous active-high reset
//   bus    fetch_sequencer_if.master (ROM address/data, bundle, handshake,
//          redirect, pc, fetch_fault)
// Optional macro ILLEGAL_TRAP_EN: unknown opcodes trap to FAULT with illegal_op.
// -----------------------------------------------------------------------------
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
    parameter logic [ADDR_W-1:0] ROM_LAST = 8'h7F
)(
    input  logic              clk,
    input  logic              reset,
    fetch_sequencer_if.master bus
);
    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    logic [ADDR_W-1:0] pc_r;
    logic [DATA_W-1:0] opcode_r;
    logic [DATA_W-1:0] operand_r;
    logic              has_operand_r;
    logic [ADDR_W-1:0] instr_pc_r;
    logic              instr_valid_r;
    logic              fetch_fault_r;
    logic              dec_has_operand_s;
    logic              dec_legal_s;

    opcode_len_decode u_decode (
        .opcode      (bus.rom_data),
        .has_operand (dec_has_operand_s),
        .legal       (dec_legal_s)
    );

`ifdef ILLEGAL_TRAP_EN
    logic illegal_op_r;
    assign bus.illegal_op = illegal_op_r;
`else
    logic unused_legal_s;
    assign unused_legal_s = dec_legal_s;
`endif

    // The ROM is always addressed by the registered PC.
    assign bus.rom_addr    = pc_r;
    assign bus.pc          = pc_r;
    assign bus.opcode      = opcode_r;
    assign bus.operand     = operand_r;
    assign bus.has_operand = has_operand_r;
    assign bus.instr_pc    = instr_pc_r;
    assign bus.instr_valid = instr_valid_r;
    assign bus.fetch_fault = fetch_fault_r;

    // Fetch FSM, PC register and registered bundle/status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_FETCH_OP;
            pc_r          <= RESET_PC;
            opcode_r      <= {DATA_W{1'b0}};
            operand_r     <= {DATA_W{1'b0}};
            has_operand_r <= 1'b0;
            instr_pc_r    <= {ADDR_W{1'b0}};
            instr_valid_r <= 1'b0;
            fetch_fault_r <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal_op_r  <= 1'b0;
`endif
        end else if (bus.redirect_valid) begin
            // Redirect wins over everything, including a same-cycle handshake;
            // any partial fetch is dropped.
            state_r       <= ST_FETCH_OP;
            pc_r          <= bus.redirect_addr;
            instr_valid_r <= 1'b0;
            fetch_fault_r <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal_op_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_FETCH_OP: begin
                    if (pc_r > ROM_LAST) begin
                        state_r       <= ST_FAULT;
                        fetch_fault_r <= 1'b1;
                    end else begin
                        state_r <= ST_LATCH_OP;
                    end
                end
                ST_LATCH_OP: begin
                    opcode_r      <= bus.rom_data;
                    instr_pc_r    <= pc_r;
                    pc_r          <= pc_r + PC_ONE;
                    has_operand_r <= dec_has_operand_s;
`ifdef ILLEGAL_TRAP_EN
                    if (!dec_legal_s) begin
                        state_r      <= ST_FAULT;
                        illegal_op_r <= 1'b1;
                    end else
`endif
                    if (dec_has_operand_s) begin
                        state_r <= ST_FETCH_ARG;
                    end else begin
                        operand_r     <= {DATA_W{1'b0}};
                        instr_valid_r <= 1'b1;
                        state_r       <= ST_VALID;
                    end
                end
                ST_FETCH_ARG: begin
                    // Operand address gets the same window check as the opcode.
                    if (pc_r > ROM_LAST) begin
                        state_r       <= ST_FAULT;
                        fetch_fault_r <= 1'b1;
                    end else begin
                        state_r <= ST_LATCH_ARG;
                    end
                end
                ST_LATCH_ARG: begin
                    operand_r     <= bus.rom_data;
                    pc_r          <= pc_r + PC_ONE;
                    instr_valid_r <= 1'b1;
                    state_r       <= ST_VALID;
                end
                ST_VALID: begin
                    if (bus.instr_ready) begin
                        instr_valid_r <= 1'b0;
                        state_r       <= ST_FETCH_OP;
                    end else begin
                        state_r <= ST_VALID;
                    end
                end
                ST_FAULT: begin
                    state_r <= ST_FAULT;
                end
                default: begin
                    state_r       <= ST_FETCH_OP;
                    instr_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
// Self-checking bench for fetch_sequencer: directed scenarios plus a randomized
// run against a bundle-level reference model of the fetch rules.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    logic [7:0] rom [256];

    localparam logic [7:0] ONE_OP_LIST [15] = '{
        LDA_IMM, LDA_DIR, LDB_IMM, LDB_DIR, STA_DIR, STB_DIR,
        BRA, BMI, BPL, BEQ, BNE, BVS, BVC, BCS, BCC};
    localparam logic [7:0] POOL [27] = '{
        LDA_IMM, LDA_DIR, LDB_IMM, LDB_DIR, STA_DIR, STB_DIR,
        BRA, BMI, BPL, BEQ, BNE, BVS, BVC, BCS, BCC,
        NOP, ADD_AB, SUB_AB, AND_AB, OR_AB, XOR_AB, NOT_A, INC_A, DEC_A, HLT,
        8'h99, 8'hA5};

    fetch_sequencer_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    fetch_sequencer #(
        .ADDR_W(8), .DATA_W(8), .RESET_PC(8'h00), .ROM_LAST(8'h7F)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous program ROM with one cycle of read latency.
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    function automatic bit needs_operand(input logic [7:0] op);
        for (int i = 0; i < 15; i++)
            if (ONE_OP_LIST[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [24:0] bundle();
        return {bus.opcode, bus.operand, bus.has_operand, bus.instr_pc};
    endfunction

    // Reference model: outcome of fetching one instruction starting at 'at'.
    task automatic predict(input logic [7:0] at, output int lat, output bit flt,
                           output logic [7:0] op, output logic [7:0] arg,
                           output bit has, output logic [7:0] nxt);
        op = 8'h00; arg = 8'h00; has = 1'b0; flt = 1'b0; nxt = at; lat = 0;
        if (at > 8'h7F) begin
            lat = 1; flt = 1'b1;
        end else begin
            op  = rom[at];
            has = needs_operand(op);
            nxt = at + 8'd1;
            if (!has) begin
                lat = 2;
            end else if (nxt > 8'h7F) begin
                lat = 3; flt = 1'b1;
            end else begin
                arg = rom[nxt];
                nxt = nxt + 8'd1;
                lat = 4;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [7:0] a);
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = a;
        step();
        bus.redirect_valid = 1'b0;
    endtask

    // Cycles until valid or fault shows up; -1 when the bound expires.
    task automatic wait_event(output int n);
        n = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (bus.instr_valid === 1'b1 || bus.fetch_fault === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [42:0] snap;
        reset = 1'b1;
        step();
        step();
        snap = {bus.pc, bus.rom_addr, bus.opcode, bus.operand, bus.has_operand,
                bus.instr_pc, bus.instr_valid, bus.fetch_fault};
        vectors++;
        if (snap !== 43'd0) begin
            miscompares++;
            $display("FAIL reset_values: got %h expected 0", snap);
        end
    endtask

    task automatic test_lda_imm();
        int n;
        bus.instr_ready = 1'b1;
        reset = 1'b0;
        wait_event(n);
        vectors++;
        if (n !== 4) begin
            miscompares++; $display("FAIL lda_latency: got %0d expected 4", n);
        end
        vectors++;
        if ({bus.instr_valid, bundle(), bus.pc} !== {1'b1, LDA_IMM, 8'h07, 1'b1, 8'h00, 8'h02}) begin
            miscompares++;
            $display("FAIL lda_bundle: got v=%b %h pc=%h", bus.instr_valid, bundle(), bus.pc);
        end
        step();
        bus.instr_ready = 1'b0;
        vectors++;
        if ({bus.instr_valid, bus.pc} !== {1'b0, 8'h02}) begin
            miscompares++;
            $display("FAIL lda_consume: got v=%b pc=%h expected v=0 pc=02", bus.instr_valid, bus.pc);
        end
    endtask

    task automatic test_sub();
        int n;
        redirect_to(8'h04);
        wait_event(n);
        vectors++;
        if (n !== 2) begin
            miscompares++; $display("FAIL sub_latency: got %0d expected 2", n);
        end
        vectors++;
        if ({bus.instr_valid, bundle(), bus.pc} !== {1'b1, SUB_AB, 8'h00, 1'b0, 8'h04, 8'h05}) begin
            miscompares++;
            $display("FAIL sub_bundle: got v=%b %h pc=%h", bus.instr_valid, bundle(), bus.pc);
        end
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
    endtask

    task automatic test_stall();
        int n;
        logic [24:0] held;
        redirect_to(8'h08);
        wait_event(n);
        held = bundle();
        vectors++;
        if ({n, held} !== {32'sd4, LDB_IMM, 8'h5A, 1'b1, 8'h08}) begin
            miscompares++; $display("FAIL stall_first: got lat=%0d %h", n, held);
        end
        for (int s = 0; s < 5; s++) begin
            step();
            vectors++;
            if ({bus.instr_valid, bundle()} !== {1'b1, LDB_IMM, 8'h5A, 1'b1, 8'h08}) begin
                miscompares++;
                $display("FAIL stall_hold: cycle %0d got v=%b %h", s, bus.instr_valid, bundle());
            end
        end
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        wait_event(n);
        vectors++;
        if ({n, bus.instr_valid, bundle()} !== {32'sd2, 1'b1, NOT_A, 8'h00, 1'b0, 8'h0A}) begin
            miscompares++;
            $display("FAIL stall_release: got lat=%0d v=%b %h", n, bus.instr_valid, bundle());
        end
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
    endtask

    task automatic test_redirect_mid();
        int n;
        redirect_to(8'h20);
        step();
        step();
        redirect_to(8'h11);
        wait_event(n);
        vectors++;
        if ({n, bus.instr_valid, bundle()} !== {32'sd2, 1'b1, ADD_AB, 8'h00, 1'b0, 8'h11}) begin
            miscompares++;
            $display("FAIL redirect_mid: got lat=%0d v=%b %h", n, bus.instr_valid, bundle());
        end
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
    endtask

    task automatic test_fault();
        int n;
        redirect_to(8'h7F);
        wait_event(n);
        vectors++;
        if ({n, bus.instr_valid, bus.fetch_fault, bus.pc} !== {32'sd3, 1'b0, 1'b1, 8'h80}) begin
            miscompares++;
            $display("FAIL fault_operand: got lat=%0d v=%b f=%b pc=%h", n, bus.instr_valid, bus.fetch_fault, bus.pc);
        end
        for (int s = 0; s < 4; s++) begin
            step();
            vectors++;
            if ({bus.instr_valid, bus.fetch_fault} !== 2'b01) begin
                miscompares++;
                $display("FAIL fault_hold: got v=%b f=%b expected v=0 f=1", bus.instr_valid, bus.fetch_fault);
            end
        end
        redirect_to(8'h00);
        vectors++;
        if (bus.fetch_fault !== 1'b0) begin
            miscompares++; $display("FAIL fault_clear: got %b expected 0", bus.fetch_fault);
        end
        wait_event(n);
        vectors++;
        if ({n, bus.instr_valid, bundle()} !== {32'sd4, 1'b1, LDA_IMM, 8'h07, 1'b1, 8'h00}) begin
            miscompares++;
            $display("FAIL fault_recover: got lat=%0d v=%b %h", n, bus.instr_valid, bundle());
        end
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
    endtask

    task automatic test_pc_overflow();
        int n;
        redirect_to(8'hC3);
        wait_event(n);
        vectors++;
        if ({n, bus.fetch_fault, bus.pc} !== {32'sd1, 1'b1, 8'hC3}) begin
            miscompares++;
            $display("FAIL overflow_far: got lat=%0d f=%b pc=%h", n, bus.fetch_fault, bus.pc);
        end
        // Last 1-operand instruction that fits, then the next fetch falls out.
        redirect_to(8'h7E);
        wait_event(n);
        vectors++;
        if ({n, bus.instr_valid, bundle(), bus.pc} !== {32'sd4, 1'b1, LDA_IMM, BRA, 1'b1, 8'h7E, 8'h80}) begin
            miscompares++;
            $display("FAIL overflow_edge: got lat=%0d v=%b %h pc=%h", n, bus.instr_valid, bundle(), bus.pc);
        end
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        wait_event(n);
        vectors++;
        if ({n, bus.instr_valid, bus.fetch_fault, bus.pc} !== {32'sd1, 1'b0, 1'b1, 8'h80}) begin
            miscompares++;
            $display("FAIL overflow_next: got lat=%0d v=%b f=%b pc=%h", n, bus.instr_valid, bus.fetch_fault, bus.pc);
        end
    endtask

    task automatic test_redirect_handshake();
        int n;
        redirect_to(8'h30);
        wait_event(n);
        bus.instr_ready = 1'b1;
        redirect_to(8'h40);
        bus.instr_ready = 1'b0;
        vectors++;
        if (bus.instr_valid !== 1'b0) begin
            miscompares++; $display("FAIL redir_hs_drop: got v=%b expected 0", bus.instr_valid);
        end
        wait_event(n);
        vectors++;
        if ({n, bus.instr_valid, bundle()} !== {32'sd2, 1'b1, DEC_A, 8'h00, 1'b0, 8'h40}) begin
            miscompares++;
            $display("FAIL redir_hs_next: got lat=%0d v=%b %h", n, bus.instr_valid, bundle());
        end
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        logic [42:0] snap;
        redirect_to(8'h50);
        step();
        step();
        step();
        vectors++;
        if ({bus.instr_valid, bus.opcode, bus.has_operand, bus.pc} !== {1'b0, LDB_IMM, 1'b1, 8'h51}) begin
            miscompares++;
            $display("FAIL reset_mid_pre: got v=%b op=%h h=%b pc=%h", bus.instr_valid, bus.opcode, bus.has_operand, bus.pc);
        end
        #2 reset = 1'b1;
        #1;
        snap = {bus.pc, bus.rom_addr, bus.opcode, bus.operand, bus.has_operand,
                bus.instr_pc, bus.instr_valid, bus.fetch_fault};
        vectors++;
        if (snap !== 43'd0) begin
            miscompares++; $display("FAIL reset_mid_async: got %h expected 0", snap);
        end
        step();
        reset = 1'b0;
        wait_event(n);
        vectors++;
        if ({n, bus.instr_valid, bundle()} !== {32'sd4, 1'b1, LDA_IMM, 8'h07, 1'b1, 8'h00}) begin
            miscompares++;
            $display("FAIL reset_mid_restart: got lat=%0d v=%b %h", n, bus.instr_valid, bundle());
        end
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
    endtask

    task automatic test_random();
        int n, e_lat, stall;
        bit e_flt, e_has;
        logic [7:0] cur, e_op, e_arg, e_nxt;
        for (int a = 0; a < 128; a++) rom[a] = POOL[$urandom_range(0, 26)];
        for (int it = 0; it < 150; it++) begin
            cur = 8'($urandom_range(0, 143));
            redirect_to(cur);
            for (int j = 0; j < 6; j++) begin
                predict(cur, e_lat, e_flt, e_op, e_arg, e_has, e_nxt);
                wait_event(n);
                vectors++;
                if (n !== e_lat) begin
                    miscompares++;
                    $display("FAIL rnd_latency: pc=%h got %0d expected %0d", cur, n, e_lat);
                end
                if (e_flt) begin
                    vectors++;
                    if ({bus.instr_valid, bus.fetch_fault, bus.pc} !== {1'b0, 1'b1, e_nxt}) begin
                        miscompares++;
                        $display("FAIL rnd_fault: got v=%b f=%b pc=%h expected pc=%h", bus.instr_valid, bus.fetch_fault, bus.pc, e_nxt);
                    end
                    break;
                end
                vectors++;
                if ({bus.instr_valid, bundle(), bus.pc} !== {1'b1, e_op, e_arg, e_has, cur, e_nxt}) begin
                    miscompares++;
                    $display("FAIL rnd_bundle: got v=%b %h pc=%h expected %h %h %b %h pc=%h",
                             bus.instr_valid, bundle(), bus.pc, e_op, e_arg, e_has, cur, e_nxt);
                end
                stall = $urandom_range(0, 3);
                for (int s = 0; s < stall; s++) begin
                    step();
                    vectors++;
                    if ({bus.instr_valid, bundle()} !== {1'b1, e_op, e_arg, e_has, cur}) begin
                        miscompares++;
                        $display("FAIL rnd_stall: got v=%b %h", bus.instr_valid, bundle());
                    end
                end
                bus.instr_ready = 1'b1;
                step();
                bus.instr_ready = 1'b0;
                vectors++;
                if (bus.instr_valid !== 1'b0) begin
                    miscompares++; $display("FAIL rnd_consume: got v=%b expected 0", bus.instr_valid);
                end
                cur = e_nxt;
            end
        end
    endtask

    initial begin
        vectors            = 0;
        miscompares        = 0;
        reset              = 1'b1;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = 8'h00;
        for (int a = 0; a < 256; a++) rom[a] = NOP;
        rom[8'h00] = LDA_IMM;  rom[8'h01] = 8'h07;
        rom[8'h04] = SUB_AB;
        rom[8'h08] = LDB_IMM;  rom[8'h09] = 8'h5A;  rom[8'h0A] = NOT_A;
        rom[8'h11] = ADD_AB;
        rom[8'h20] = LDA_DIR;  rom[8'h21] = 8'h33;
        rom[8'h30] = INC_A;    rom[8'h40] = DEC_A;
        rom[8'h50] = LDB_IMM;  rom[8'h51] = 8'h66;
        rom[8'h7E] = LDA_IMM;  rom[8'h7F] = BRA;

        test_reset();
        test_lda_imm();
        test_sub();
        test_stall();
        test_redirect_mid();
        test_fault();
        test_pc_overflow();
        test_redirect_handshake();
        test_reset_mid();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
